turn_phase_ctrl: RTL
====================

Name: turn_phase_ctrl

Overview:
Turn sequencer that drives the card decoder (decode_TOP) through the Dominion turn phases START → ACTION → ACTIONEND → BUY → DRAW, and ENDGAME at game end.
- Feeds played cards to the decoder one at a time and waits for the decoder's nextcard handshake.
- Accumulates the decoder's action/buy/draw/gold yields into per-turn resource counters.
- Arbitrates player play, buy and end-phase requests against those counters.

Parameters:
HAND_SIZE, 5, number of draw requests issued in the DRAW phase
DEC_TIMEOUT, 15, cycles to wait for dec_nextcard before abandoning a card
PHASE_TIMEOUT, 1000, idle cycles before a forced phase end (optional feature only)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin game; honoured only in IDLE
game_over  in  1  supply-exhausted flag; sticky-latched internally
play_req  in  1  player plays play_card (action card in ACTION, treasure in BUY)
play_card  in  4  card id
buy_req  in  1  purchase request
buy_cost  in  5  cost of requested card
end_phase  in  1  player ends current phase
dec_action  in  3  decoder +actions yield
dec_buy  in  3  decoder +buys yield
dec_draw  in  3  decoder +cards yield
dec_gold  in  5  decoder gold yield
dec_nextcard  in  1  decoder done with current card
mode  out  3  phase code to decoder
card_stream  out  4  card presented to decoder
card_valid  out  1  card_stream valid
actions_left  out  3  remaining actions
buys_left  out  3  remaining buys
gold_avail  out  5  spendable gold; also drives the decoder's gold_in_bank
draw_req  out  1  one-cycle pulse, draw one card
play_ack  out  1  one-cycle pulse, card accepted and decoded
buy_ack  out  1  one-cycle pulse, buy granted
buy_nak  out  1  one-cycle pulse, buy refused
turn_cnt  out  8  completed turns, wraps at 255

Behaviour:
- Reset (async, active-low) returns state to IDLE from any state, including mid-operation. All outputs go to 0 except mode = START (1). The game_over latch is cleared.
- States: IDLE, START, ACTION, ACT_WAIT, ACTIONEND, BUY, BUY_WAIT, DRAW, ENDGAME.
- mode by state: IDLE/START → 1; ACTION/ACT_WAIT → 2; ACTIONEND → 3; BUY/BUY_WAIT → 4; DRAW → 5; ENDGAME → 6.
- IDLE → START on start. In any other state, start is ignored.
- START (1 cycle): actions_left = 1, buys_left = 1, gold_avail = 0, draw pending = 0; then → ACTION.
- ACTION:
  - If draw pending > 0: emit one draw_req per cycle, decrementing the pending count. play_req is ignored until pending reaches 0.
  - Else, play_req with actions_left > 0: card_stream = play_card, card_valid = 1, actions_left -= 1, → ACT_WAIT.
  - Else, end_phase or actions_left == 0 → ACTIONEND.
  - play_req and end_phase in the same cycle: play_req wins; end_phase is dropped.
- ACT_WAIT:
  - card_valid and card_stream held until dec_nextcard.
  - On dec_nextcard (same edge): actions_left += dec_action, buys_left += dec_buy, gold_avail += dec_gold, draw pending += dec_draw; play_ack pulses; card_valid drops; → ACTION.
  - Arithmetic: all additions saturate at the field maximum (7 for 3-bit, 31 for 5-bit). No wrap.
  - After DEC_TIMEOUT cycles without dec_nextcard: drop the card, do not refund the action, no play_ack, → ACTION.
- ACTIONEND: one cycle, → BUY.
- BUY:
  - play_req: present the card as in ACTION (no action cost), → BUY_WAIT. Only dec_gold and dec_buy are accumulated.
  - buy_req: if buys_left > 0 and buy_cost <= gold_avail, then gold_avail -= buy_cost, buys_left -= 1, buy_ack pulses. Otherwise buy_nak pulses and nothing changes.
  - Priority in one cycle: play_req > buy_req > end_phase.
  - → DRAW on end_phase, or on the cycle after buys_left reaches 0.
- BUY_WAIT: same handshake and timeout as ACT_WAIT; returns to BUY.
- DRAW:
  - Emit exactly HAND_SIZE draw_req pulses on consecutive cycles.
  - Zero actions_left, buys_left and gold_avail.
  - turn_cnt += 1.
  - → ENDGAME if game_over is latched, else → START.
- game_over asserted at any time is latched and takes effect only at DRAW exit; the current turn always completes.
- ENDGAME: terminal until reset. card_valid = 0; all request inputs ignored.

Optional Feature:
Macro PHASE_TIMEOUT_EN.
- Defined: in ACTION and BUY, a counter clears on any accepted play_req/buy_req/end_phase. Reaching PHASE_TIMEOUT acts as an end_phase.
- Undefined: no counter; phases end only by player input or exhausted resources.

Decomposition:
- Shared package dominion_pkg holds:
  - mode codes START = 1, ACTION = 2, ACTIONEND = 3, BUY = 4, DRAW = 5, ENDGAME = 6;
  - the state enum typedef;
  - width constants: CARD_W = 4, RES_W = 3, GOLD_W = 5.
- One natural sub-module: turn_res_counters, holding the saturating action/buy/gold/draw-pending registers with load/add/subtract controls.

Test Plan:
- Reset low mid-ACT_WAIT → next edge state IDLE, mode = 1, card_valid = 0, all counters 0.
- start; play_req card 6 with dec_action = 2, dec_draw = 2 after 3 cycles → play_ack; actions_left = 2; exactly 2 draw_req pulses before the next play is accepted.
- BUY, gold_avail = 3, buy_req cost 5 → buy_nak, gold 3; then play treasure dec_gold = 3, buy cost 5 → buy_ack, gold 1, buys 0, → DRAW.
- DRAW → exactly 5 consecutive draw_req pulses; turn_cnt 0 → 1; mode returns to 1, then 2.
- Saturation: actions 6 + dec_action 3 → 7; gold 30 + dec_gold 5 → 31.
- game_over pulsed in ACTION → turn completes through DRAW, then mode = 6; subsequent start/play_req ignored; dec_nextcard never asserted → card dropped after 15 cycles, no play_ack.

Source files
------------

// File: rtl/dominion_pkg.sv
// dominion_pkg
//   Shared definitions for the Dominion turn sequencer: data widths, the
//   phase codes presented to the card decoder, the sequencer state type and
//   small saturating-arithmetic helpers.
package dominion_pkg;

    localparam int CARD_W = 4;
    localparam int RES_W  = 3;
    localparam int GOLD_W = 5;

    localparam logic [2:0] MODE_START     = 3'd1;
    localparam logic [2:0] MODE_ACTION    = 3'd2;
    localparam logic [2:0] MODE_ACTIONEND = 3'd3;
    localparam logic [2:0] MODE_BUY       = 3'd4;
    localparam logic [2:0] MODE_DRAW      = 3'd5;
    localparam logic [2:0] MODE_ENDGAME   = 3'd6;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ACTION,
        ST_ACT_WAIT,
        ST_ACTIONEND,
        ST_BUY,
        ST_BUY_WAIT,
        ST_DRAW,
        ST_ENDGAME
    } state_e;

    function automatic logic [RES_W-1:0] sat_add_res(input logic [RES_W-1:0] a,
                                                     input logic [RES_W-1:0] b);
        logic [RES_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[RES_W] ? {RES_W{1'b1}} : s[RES_W-1:0];
    endfunction

    function automatic logic [GOLD_W-1:0] sat_add_gold(input logic [GOLD_W-1:0] a,
                                                       input logic [GOLD_W-1:0] b);
        logic [GOLD_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[GOLD_W] ? {GOLD_W{1'b1}} : s[GOLD_W-1:0];
    endfunction

    function automatic logic [2:0] mode_of(input state_e st);
        case (st)
            ST_ACTION, ST_ACT_WAIT: return MODE_ACTION;
            ST_ACTIONEND:           return MODE_ACTIONEND;
            ST_BUY, ST_BUY_WAIT:    return MODE_BUY;
            ST_DRAW:                return MODE_DRAW;
            ST_ENDGAME:             return MODE_ENDGAME;
            default:                return MODE_START;
        endcase
    endfunction

endpackage

// File: rtl/turn_res_counters.sv
// turn_res_counters
//   Per-turn resource registers (actions, buys, gold, pending draws).
//   All decoder yields saturate; decrements are only requested when the
//   field is known to be non-zero (or cost <= gold).
// Ports:
//   clk_i, rst_ni           clock, async active-low reset
//   clear_i                 zero all fields
//   load_start_i            load turn-start values (1 action, 1 buy)
//   use_action_i            actions -= 1
//   take_draw_i             pending draws -= 1
//   spend_i, cost_i         buys -= 1, gold -= cost
//   acc_i                   accumulate buy/gold yields
//   acc_act_i               with acc_i, also accumulate action/draw yields
//   add_*_i                 decoder yields
//   actions_o, buys_o, gold_o, pending_o   current values
module turn_res_counters
    import dominion_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              load_start_i,
    input  logic              use_action_i,
    input  logic              take_draw_i,
    input  logic              spend_i,
    input  logic [GOLD_W-1:0] cost_i,
    input  logic              acc_i,
    input  logic              acc_act_i,
    input  logic [RES_W-1:0]  add_action_i,
    input  logic [RES_W-1:0]  add_buy_i,
    input  logic [RES_W-1:0]  add_draw_i,
    input  logic [GOLD_W-1:0] add_gold_i,
    output logic [RES_W-1:0]  actions_o,
    output logic [RES_W-1:0]  buys_o,
    output logic [GOLD_W-1:0] gold_o,
    output logic [RES_W-1:0]  pending_o
);

    logic [RES_W-1:0]  act_q, act_d;
    logic [RES_W-1:0]  buy_q, buy_d;
    logic [RES_W-1:0]  pend_q, pend_d;
    logic [GOLD_W-1:0] gold_q, gold_d;

    always_comb begin
        act_d  = act_q;
        buy_d  = buy_q;
        pend_d = pend_q;
        gold_d = gold_q;
        if (clear_i) begin
            act_d  = '0;
            buy_d  = '0;
            pend_d = '0;
            gold_d = '0;
        end else if (load_start_i) begin
            act_d  = RES_W'(1);
            buy_d  = RES_W'(1);
            pend_d = '0;
            gold_d = '0;
        end else begin
            if (use_action_i) act_d  = act_q - 1'b1;
            if (take_draw_i)  pend_d = pend_q - 1'b1;
            if (spend_i) begin
                buy_d  = buy_q - 1'b1;
                gold_d = gold_q - cost_i;
            end
            if (acc_i) begin
                buy_d  = sat_add_res(buy_q, add_buy_i);
                gold_d = sat_add_gold(gold_q, add_gold_i);
                if (acc_act_i) begin
                    act_d  = sat_add_res(act_q, add_action_i);
                    pend_d = sat_add_res(pend_q, add_draw_i);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            act_q  <= '0;
            buy_q  <= '0;
            pend_q <= '0;
            gold_q <= '0;
        end else begin
            act_q  <= act_d;
            buy_q  <= buy_d;
            pend_q <= pend_d;
            gold_q <= gold_d;
        end
    end

    assign actions_o = act_q;
    assign buys_o    = buy_q;
    assign gold_o    = gold_q;
    assign pending_o = pend_q;

endmodule

// File: rtl/turn_phase_ctrl.sv
// turn_phase_ctrl
//   Dominion turn sequencer driving the card decoder through
//   START -> ACTION -> ACTIONEND -> BUY -> DRAW, and ENDGAME at game end.
//   Optional build macro PHASE_TIMEOUT_EN: ACTION/BUY end on their own after
//   PHASE_TIMEOUT cycles without an accepted player request.
// Ports:
//   clk, reset (async, active-low)
//   start, game_over, play_req/play_card, buy_req/buy_cost, end_phase  player side
//   dec_action/buy/draw/gold, dec_nextcard                             decoder yields
//   mode, card_stream, card_valid                                      to decoder
//   actions_left, buys_left, gold_avail                                resources
//   draw_req, play_ack, buy_ack, buy_nak                               1-cycle pulses
//   turn_cnt                                                           completed turns
module turn_phase_ctrl
    import dominion_pkg::*;
#(
    parameter int unsigned HAND_SIZE     = 5,
    parameter int unsigned DEC_TIMEOUT   = 15,
    parameter int unsigned PHASE_TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              game_over,
    input  logic              play_req,
    input  logic [CARD_W-1:0] play_card,
    input  logic              buy_req,
    input  logic [GOLD_W-1:0] buy_cost,
    input  logic              end_phase,
    input  logic [RES_W-1:0]  dec_action,
    input  logic [RES_W-1:0]  dec_buy,
    input  logic [RES_W-1:0]  dec_draw,
    input  logic [GOLD_W-1:0] dec_gold,
    input  logic              dec_nextcard,
    output logic [2:0]        mode,
    output logic [CARD_W-1:0] card_stream,
    output logic              card_valid,
    output logic [RES_W-1:0]  actions_left,
    output logic [RES_W-1:0]  buys_left,
    output logic [GOLD_W-1:0] gold_avail,
    output logic              draw_req,
    output logic              play_ack,
    output logic              buy_ack,
    output logic              buy_nak,
    output logic [7:0]        turn_cnt
);

    // One counter serves the decoder wait, the DRAW pulse train and the
    // optional phase timeout; it restarts on every state change.
    localparam int unsigned CNT_A   = (DEC_TIMEOUT > HAND_SIZE) ? DEC_TIMEOUT : HAND_SIZE;
    localparam int unsigned CNT_MAX = (CNT_A > PHASE_TIMEOUT) ? CNT_A : PHASE_TIMEOUT;
    localparam int          CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(DEC_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DRAW_LAST = CNT_W'(HAND_SIZE - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CARD_W-1:0] card_q, card_d;
    logic [7:0]        turn_q, turn_d;
    logic              go_q;
    logic              play_ack_q, play_ack_d;
    logic              buy_ack_q, buy_ack_d;
    logic              buy_nak_q, buy_nak_d;

    logic              accept, clear, load_start, use_action, take_draw;
    logic              spend, acc, acc_act, phase_to;
    logic [RES_W-1:0]  act_w, buy_w, pend_w;
    logic [GOLD_W-1:0] gold_w;

`ifdef PHASE_TIMEOUT_EN
    localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PHASE_TIMEOUT - 1);
    assign phase_to = (cnt_q == PHASE_LAST);
`else
    assign phase_to = 1'b0;
`endif

    turn_res_counters u_res (
        .clk_i        (clk),
        .rst_ni       (reset),
        .clear_i      (clear),
        .load_start_i (load_start),
        .use_action_i (use_action),
        .take_draw_i  (take_draw),
        .spend_i      (spend),
        .cost_i       (buy_cost),
        .acc_i        (acc),
        .acc_act_i    (acc_act),
        .add_action_i (dec_action),
        .add_buy_i    (dec_buy),
        .add_draw_i   (dec_draw),
        .add_gold_i   (dec_gold),
        .actions_o    (act_w),
        .buys_o       (buy_w),
        .gold_o       (gold_w),
        .pending_o    (pend_w)
    );

    always_comb begin
        state_d    = state_q;
        card_d     = card_q;
        turn_d     = turn_q;
        play_ack_d = 1'b0;
        buy_ack_d  = 1'b0;
        buy_nak_d  = 1'b0;
        accept     = 1'b0;
        clear      = 1'b0;
        load_start = 1'b0;
        use_action = 1'b0;
        take_draw  = 1'b0;
        spend      = 1'b0;
        acc        = 1'b0;
        acc_act    = 1'b0;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_START;
            ST_START: begin
                load_start = 1'b1;
                state_d    = ST_ACTION;
            end
            ST_ACTION: begin
                // Pending draws are drained before any further play.
                if (pend_w != '0) begin
                    take_draw = 1'b1;
                end else if (play_req && act_w != '0) begin
                    card_d     = play_card;
                    use_action = 1'b1;
                    accept     = 1'b1;
                    state_d    = ST_ACT_WAIT;
                end else if (end_phase || act_w == '0 || phase_to) begin
                    state_d = ST_ACTIONEND;
                end
            end
            ST_ACT_WAIT, ST_BUY_WAIT: begin
                if (dec_nextcard) begin
                    acc        = 1'b1;
                    acc_act    = (state_q == ST_ACT_WAIT);
                    play_ack_d = 1'b1;
                    state_d    = (state_q == ST_ACT_WAIT) ? ST_ACTION : ST_BUY;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d = (state_q == ST_ACT_WAIT) ? ST_ACTION : ST_BUY;
                end
            end
            ST_ACTIONEND: state_d = ST_BUY;
            ST_BUY: begin
                // Resources are zeroed on the way into DRAW.
                if (buy_w == '0) begin
                    clear   = 1'b1;
                    state_d = ST_DRAW;
                end else if (play_req) begin
                    card_d  = play_card;
                    accept  = 1'b1;
                    state_d = ST_BUY_WAIT;
                end else if (buy_req) begin
                    accept = 1'b1;
                    if (buy_cost <= gold_w) begin
                        spend     = 1'b1;
                        buy_ack_d = 1'b1;
                    end else begin
                        buy_nak_d = 1'b1;
                    end
                end else if (end_phase || phase_to) begin
                    clear   = 1'b1;
                    state_d = ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (cnt_q == DRAW_LAST) begin
                    turn_d  = turn_q + 8'd1;
                    state_d = (go_q || game_over) ? ST_ENDGAME : ST_START;
                end
            end
            ST_ENDGAME: ;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q || accept) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            card_q     <= '0;
            turn_q     <= '0;
            go_q       <= 1'b0;
            play_ack_q <= 1'b0;
            buy_ack_q  <= 1'b0;
            buy_nak_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            card_q     <= card_d;
            turn_q     <= turn_d;
            go_q       <= go_q | game_over;
            play_ack_q <= play_ack_d;
            buy_ack_q  <= buy_ack_d;
            buy_nak_q  <= buy_nak_d;
        end
    end

    assign mode         = mode_of(state_q);
    assign card_valid   = (state_q == ST_ACT_WAIT) || (state_q == ST_BUY_WAIT);
    assign card_stream  = card_valid ? card_q : '0;
    assign actions_left = act_w;
    assign buys_left    = buy_w;
    assign gold_avail   = gold_w;
    assign draw_req     = (state_q == ST_ACTION && pend_w != '0) || (state_q == ST_DRAW);
    assign play_ack     = play_ack_q;
    assign buy_ack      = buy_ack_q;
    assign buy_nak      = buy_nak_q;
    assign turn_cnt     = turn_q;

endmodule
